// File: rtl/spi_master.sv
// spi_master: SPI mode-0 initiator that turns single register commands into 32-bit frames
module spi_master #(
    parameter int unsigned CLK_DIV   = 8,
    parameter int unsigned SETUP_CYC = 8,
    parameter int unsigned GAP_CYC   = 16,
    parameter logic [7:0]  CHIP_IDW  = 8'h64,
    parameter logic [7:0]  CHIP_IDR  = 8'h65
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_rw,
    input  logic [7:0]  cmd_addr,
    input  logic [15:0] cmd_wdata,
    output logic        done,
    output logic [15:0] rd_data,
    output logic        busy,
    output logic        ss,
    output logic        sck,
    output logic        mosi,
    input  logic        miso
);
    localparam int unsigned HW   = $clog2(CLK_DIV) + 1;
    localparam int unsigned PMAX = SETUP_CYC > GAP_CYC ? SETUP_CYC : GAP_CYC;
    localparam int unsigned PW   = $clog2(PMAX) + 1;

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t        state_q, state_d;
    logic [HW-1:0] hc_q, hc_d;
    logic [PW-1:0] cnt_q, cnt_d;
    logic [5:0]    bit_q, bit_d;
    logic [30:0]   tx_q, tx_d;
    logic [15:0]   rx_q, rx_d;
    logic [15:0]   rd_q, rd_d;
    logic          ss_q, ss_d, sck_q, sck_d, mosi_q, mosi_d, done_q, done_d, rw_q, rw_d;
    logic [31:0]   frame;
    logic          accept, hc_end, rise, fall, last, setup_end, gap_end, hold_end;

    // tx_q holds only the bits still to be sent after the one on mosi; rx_q keeps
    // just the last 16 sampled bits since only the data phase is ever returned
    assign frame     = {cmd_rw ? CHIP_IDR : CHIP_IDW, cmd_addr, cmd_rw ? 16'h0 : cmd_wdata};
    assign accept    = state_q == IDLE && cmd_valid;
    assign hc_end    = hc_q == HW'(CLK_DIV - 1);
    assign rise      = state_q == SHIFT && hc_end && !sck_q;
    assign fall      = state_q == SHIFT && hc_end && sck_q;
    assign last      = bit_q == 6'd31;
    assign setup_end = cnt_q == PW'(SETUP_CYC - 1);
    assign gap_end   = cnt_q == PW'(GAP_CYC - 1);
    assign hold_end  = state_q == HOLD && setup_end;

    assign ss      = ss_q;
    assign sck     = sck_q;
    assign mosi    = mosi_q;
    assign done    = done_q;
    assign rd_data = rd_q;

    // state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // frame sequencing: setup, 64 half-periods, hold, inter-frame gap
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_valid) state_d = SETUP;
            SETUP:   if (setup_end) state_d = SHIFT;
            SHIFT:   if (fall && last) state_d = HOLD;
            HOLD:    if (setup_end) state_d = GAP;
            GAP:     if (gap_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // handshake outputs and next values of the pin and shift registers
    always_comb begin
        cmd_ready = state_q == IDLE;
        busy      = state_q != IDLE;
        hc_d      = (state_q == SHIFT && !hc_end) ? hc_q + HW'(1) : '0;
        cnt_d     = (state_d == state_q && (state_q == SETUP || state_q == HOLD || state_q == GAP))
                    ? cnt_q + PW'(1) : '0;
        sck_d     = (state_q == SHIFT) ? sck_q ^ hc_end : 1'b0;
        bit_d     = accept ? 6'd0 : fall ? bit_q + 6'd1 : bit_q;
        tx_d      = accept ? frame[30:0] : fall ? {tx_q[29:0], 1'b0} : tx_q;
        mosi_d    = accept ? frame[31] : fall ? (!last && tx_q[30]) : mosi_q;
        rx_d      = rise ? {rx_q[14:0], miso} : rx_q;
        ss_d      = accept ? 1'b0 : hold_end ? 1'b1 : ss_q;
        done_d    = hold_end;
        rd_d      = (hold_end && rw_q) ? rx_q : rd_q;
        rw_d      = accept ? cmd_rw : rw_q;
    end

    // datapath registers; reset forces idle pin levels and abandons any frame
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hc_q   <= '0;
            cnt_q  <= '0;
            bit_q  <= '0;
            tx_q   <= '0;
            rx_q   <= '0;
            rd_q   <= '0;
            ss_q   <= 1'b1;
            sck_q  <= 1'b0;
            mosi_q <= 1'b0;
            done_q <= 1'b0;
            rw_q   <= 1'b0;
        end else begin
            hc_q   <= hc_d;
            cnt_q  <= cnt_d;
            bit_q  <= bit_d;
            tx_q   <= tx_d;
            rx_q   <= rx_d;
            rd_q   <= rd_d;
            ss_q   <= ss_d;
            sck_q  <= sck_d;
            mosi_q <= mosi_d;
            done_q <= done_d;
            rw_q   <= rw_d;
        end
    end
endmodule
